col2im: RTL and testbench

COL2IM -- requirements
Module: col2im

---
 rtl/col2im_pkg.sv | 28 ++
 rtl/col2im_if.sv | 31 +++
 rtl/col2im_addr_gen.sv | 48 ++++
 rtl/col2im.sv | 180 ++++++++++++++++++
 tb/tb_col2im.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/col2im_pkg.sv
// Shared definitions for the col2im/im2col pair: FSM encoding and
// padding / tap-range helpers evaluated at elaboration time.
package col2im_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_ACC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Zero padding that keeps the output image the same size as the input.
  function automatic int pad_of(input int k);
    return (k - 1) / 2;
  endfunction

  // Index of the final filter tap along one axis.
  function automatic int tap_last(input int k);
    return k - 1;
  endfunction

  // Counter width that stays legal for a range of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/col2im_if.sv
// Control and memory bus of col2im, plus the FSM state for observation.
interface col2im_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
);
  import col2im_pkg::*;

  // start is a one-cycle request, only taken in IDLE or DONE; done stays high
  // until the next accepted start. Reads: data_rd must carry mem[addr_rd]
  // one cycle after addr_rd is presented. Writes: one element per cycle
  // that mem_wr_en is high, at addr_wr with data_wr.
  logic                  start;
  logic                  done;
  logic [DATA_WIDTH-1:0] data_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  mem_wr_en;
  state_t                state;

  modport master (
    input  start, data_rd,
    output done, addr_rd, addr_wr, data_wr, mem_wr_en, state
  );

  modport slave (
    output start, data_rd,
    input  done, addr_rd, addr_wr, data_wr, mem_wr_en, state
  );

endinterface

// File: rtl/col2im_addr_gen.sv
// Combinational tap validity and read/write addresses for the current
// pixel (c, ih, iw) and filter tap (fh, fw).
module col2im_addr_gen
  import col2im_pkg::*;
#(
  parameter int          IMG_C       = 1,
  parameter int          IMG_W       = 8,
  parameter int          IMG_H       = 8,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          FILTER_SIZE = 3,
  parameter int unsigned COL_BASE    = 32'h2000,
  parameter int unsigned OUT_BASE    = 32'h4000,
  parameter int          CW          = cnt_w(IMG_C),
  parameter int          HW          = cnt_w(IMG_H),
  parameter int          WW          = cnt_w(IMG_W),
  parameter int          KW          = cnt_w(FILTER_SIZE)
) (
  input  logic [CW-1:0]         c,
  input  logic [HW-1:0]         ih,
  input  logic [WW-1:0]         iw,
  input  logic [KW-1:0]         fh,
  input  logic [KW-1:0]         fw,
  output logic                  tap_valid,
  output logic [ADDR_WIDTH-1:0] addr_rd,
  output logic [ADDR_WIDTH-1:0] addr_wr
);

  localparam int K     = FILTER_SIZE;
  localparam int P     = pad_of(FILTER_SIZE);
  localparam int PLANE = IMG_H * IMG_W;

  int tap_h;
  int tap_w;
  int plane_idx;

  // Patch position that contributed this tap; may fall outside the image.
  always_comb begin
    tap_h     = int'(ih) + P - int'(fh);
    tap_w     = int'(iw) + P - int'(fw);
    plane_idx = int'(c) * K * K + int'(fh) * K + int'(fw);
    tap_valid = (tap_h >= 0) && (tap_h < IMG_H) && (tap_w >= 0) && (tap_w < IMG_W);
    addr_rd   = ADDR_WIDTH'(COL_BASE)
              + ADDR_WIDTH'(plane_idx * PLANE + tap_h * IMG_W + tap_w);
    addr_wr   = ADDR_WIDTH'(OUT_BASE)
              + ADDR_WIDTH'(int'(c) * PLANE + int'(ih) * IMG_W + int'(iw));
  end

endmodule

// File: rtl/col2im.sv
// col2im: folds a column matrix back into an image by summing every
// overlapping filter tap per output pixel, saturating to DATA_WIDTH.
module col2im
  import col2im_pkg::*;
#(
  parameter int          IMG_C       = 1,
  parameter int          IMG_W       = 8,
  parameter int          IMG_H       = 8,
  parameter int          DATA_WIDTH  = 8,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          FILTER_SIZE = 3,
  parameter int unsigned COL_BASE    = 32'h2000,
  parameter int unsigned OUT_BASE    = 32'h4000
) (
  input logic       clk,
  input logic       rst,
  col2im_if.master  bus
);

  localparam int CW    = cnt_w(IMG_C);
  localparam int HW    = cnt_w(IMG_H);
  localparam int WW    = cnt_w(IMG_W);
  localparam int KW    = cnt_w(FILTER_SIZE);
  localparam int ACC_W = DATA_WIDTH + 4;

  localparam logic [CW-1:0] C_LAST = CW'(IMG_C - 1);
  localparam logic [HW-1:0] H_LAST = HW'(IMG_H - 1);
  localparam logic [WW-1:0] W_LAST = WW'(IMG_W - 1);
  localparam logic [KW-1:0] K_LAST = KW'(tap_last(FILTER_SIZE));

  state_t state_q, state_d;

  logic [CW-1:0]         c_q, c_n;
  logic [HW-1:0]         ih_q, ih_n;
  logic [WW-1:0]         iw_q, iw_n;
  logic [KW-1:0]         fh_q, fh_n;
  logic [KW-1:0]         fw_q, fw_n;
  logic [ACC_W-1:0]      acc_q, acc_sum;
  logic [ADDR_WIDTH-1:0] addr_q, addr_wr_q;
  logic [ADDR_WIDTH-1:0] gen_addr_rd, gen_addr_wr;
  logic [DATA_WIDTH-1:0] data_wr_q, sat_val;
  logic                  wr_en_q;
  logic                  tap_valid, last_tap, last_pix;

  col2im_addr_gen #(
    .IMG_C      (IMG_C),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FILTER_SIZE(FILTER_SIZE),
    .COL_BASE   (COL_BASE),
    .OUT_BASE   (OUT_BASE),
    .CW         (CW),
    .HW         (HW),
    .WW         (WW),
    .KW         (KW)
  ) u_addr_gen (
    .c        (c_q),
    .ih       (ih_q),
    .iw       (iw_q),
    .fh       (fh_q),
    .fw       (fw_q),
    .tap_valid(tap_valid),
    .addr_rd  (gen_addr_rd),
    .addr_wr  (gen_addr_wr)
  );

  assign last_tap = (fh_q == K_LAST) && (fw_q == K_LAST);
  assign last_pix = (c_q == C_LAST) && (ih_q == H_LAST) && (iw_q == W_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (bus.start) state_d = ST_SCAN;
      ST_SCAN: begin
        if (tap_valid)     state_d = ST_ACC;
        else if (last_tap) state_d = ST_WRITE;
      end
      ST_ACC:   state_d = last_tap ? ST_WRITE : ST_SCAN;
      ST_WRITE: state_d = last_pix ? ST_DONE : ST_SCAN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Tap counters wrap after (K-1,K-1); pixel counters run iw, ih, then c.
  always_comb begin
    fw_n = fw_q + KW'(1);
    fh_n = fh_q;
    if (fw_q == K_LAST) begin
      fw_n = '0;
      fh_n = (fh_q == K_LAST) ? '0 : fh_q + KW'(1);
    end
    iw_n = iw_q + WW'(1);
    ih_n = ih_q;
    c_n  = c_q;
    if (iw_q == W_LAST) begin
      iw_n = '0;
      ih_n = ih_q + HW'(1);
      if (ih_q == H_LAST) begin
        ih_n = '0;
        c_n  = (c_q == C_LAST) ? '0 : c_q + CW'(1);
      end
    end
  end

  // Running sum including the tap being consumed this cycle, clamped on output.
  always_comb begin
    acc_sum = acc_q;
    if (state_q == ST_ACC) acc_sum = acc_q + ACC_W'(bus.data_rd);
    sat_val = (|acc_sum[ACC_W-1:DATA_WIDTH]) ? '1 : acc_sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q       <= '0;
      ih_q      <= '0;
      iw_q      <= '0;
      fh_q      <= '0;
      fw_q      <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      addr_wr_q <= '0;
      data_wr_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      wr_en_q <= (state_d == ST_WRITE);
      if (state_d == ST_WRITE) begin
        addr_wr_q <= gen_addr_wr;
        data_wr_q <= sat_val;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            c_q   <= '0;
            ih_q  <= '0;
            iw_q  <= '0;
            fh_q  <= '0;
            fw_q  <= '0;
            acc_q <= '0;
          end
        end
        ST_SCAN: begin
          if (tap_valid) begin
            addr_q <= gen_addr_rd;
          end else begin
            fh_q <= fh_n;
            fw_q <= fw_n;
          end
        end
        ST_ACC: begin
          acc_q <= acc_sum;
          fh_q  <= fh_n;
          fw_q  <= fw_n;
        end
        ST_WRITE: begin
          acc_q <= '0;
          c_q   <= c_n;
          ih_q  <= ih_n;
          iw_q  <= iw_n;
        end
        default: ;
      endcase
    end
  end

  // The read address is live during the SCAN cycle of a valid tap so the
  // memory returns data in the following ACC cycle; otherwise it holds.
  assign bus.addr_rd   = (state_q == ST_SCAN && tap_valid) ? gen_addr_rd : addr_q;
  assign bus.addr_wr   = addr_wr_q;
  assign bus.data_wr   = data_wr_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_col2im.sv
// Bench for col2im: a K=3 (C=1) and a K=1 (C=2) instance on 4x4 images,
// checked against a reference that sums overlapping taps directly.
module tb_col2im;
  import col2im_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int H     = 4;
  localparam int W     = 4;
  localparam int COLB  = 32'h2000;
  localparam int OUTB  = 32'h4000;
  localparam int MEM_N = 256;
  localparam int TMO   = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [DW-1:0]    col     [2][MEM_N];
  logic [DW-1:0]    out_mem [2][MEM_N];
  logic [AW+DW-1:0] exp_q0[$];
  logic [AW+DW-1:0] exp_q1[$];
  int               wr_cnt  [2];
  int               last_wr1;
  bit               have_prev1;

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  col2im_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  col2im_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

  col2im #(
    .IMG_C(1), .IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .FILTER_SIZE(3), .COL_BASE(COLB), .OUT_BASE(OUTB)
  ) u_k3 (.clk(clk), .rst(rst), .bus(b0));

  col2im #(
    .IMG_C(2), .IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .FILTER_SIZE(1), .COL_BASE(COLB), .OUT_BASE(OUTB)
  ) u_k1 (.clk(clk), .rst(rst), .bus(b1));

  function automatic logic [DW-1:0] rd_mem(input int id, input logic [AW-1:0] a);
    int idx;
    idx = int'(a) - COLB;
    if (idx < 0 || idx >= MEM_N) return '0;
    return col[id][idx];
  endfunction

  // Column memory: one-cycle read latency.
  always @(posedge clk) begin
    b0.data_rd <= rd_mem(0, b0.addr_rd);
    b1.data_rd <= rd_mem(1, b1.addr_rd);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: out(c,ih,iw) = sat( sum of in-range taps of the column matrix )
  function automatic int ref_pix(input int id, input int k, input int ch, input int ih, input int iw);
    int p;
    int sum;
    p   = (k - 1) / 2;
    sum = 0;
    for (int fh = 0; fh < k; fh++) begin
      for (int fw = 0; fw < k; fw++) begin
        int h;
        int w;
        h = ih + p - fh;
        w = iw + p - fw;
        if (h >= 0 && h < H && w >= 0 && w < W)
          sum += int'(col[id][(ch * k * k + fh * k + fw) * H * W + h * W + w]);
      end
    end
    return (sum > 255) ? 255 : sum;
  endfunction

  task automatic push_expected(input int id);
    int k;
    int nc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    k  = (id == 0) ? 3 : 1;
    nc = (id == 0) ? 1 : 2;
    for (int c = 0; c < nc; c++)
      for (int ih = 0; ih < H; ih++)
        for (int iw = 0; iw < W; iw++) begin
          a = AW'(OUTB + c * H * W + ih * W + iw);
          d = DW'(ref_pix(id, k, c, ih, iw));
          if (id == 0) exp_q0.push_back({a, d});
          else         exp_q1.push_back({a, d});
        end
  endtask

  // mode 0: all ones, 1: element index, 2: all 8'hFF, else random
  task automatic fill(input int id, input int mode);
    for (int i = 0; i < MEM_N; i++) begin
      case (mode)
        0:       col[id][i] = 8'd1;
        1:       col[id][i] = DW'(i);
        2:       col[id][i] = 8'hFF;
        default: col[id][i] = DW'($urandom_range(0, 255));
      endcase
    end
  endtask

  // scoreboard monitor
  task automatic mon_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [AW+DW-1:0] e;
    int oi;
    wr_cnt[id]++;
    if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_write_%0d: got addr %0h data %0h, required no write", id, a, d);
      return;
    end
    e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    check((id == 0) ? "k3_wr_addr" : "k1_wr_addr", longint'(a), longint'(e[AW+DW-1:DW]));
    check((id == 0) ? "k3_wr_data" : "k1_wr_data", longint'(d), longint'(e[DW-1:0]));
    oi = int'(a) - OUTB;
    if (oi >= 0 && oi < MEM_N) out_mem[id][oi] = d;
  endtask

  always @(negedge clk) begin
    if (b0.mem_wr_en) mon_write(0, b0.addr_wr, b0.data_wr);
    if (b1.mem_wr_en) begin
      if (have_prev1) check("k1_cycles_per_pixel", longint'(cyc - last_wr1), 3);
      have_prev1 = 1'b1;
      last_wr1   = cyc;
      mon_write(1, b1.addr_wr, b1.data_wr);
    end
  end

  // driver tasks
  function automatic logic done_of(input int id);
    return (id == 0) ? b0.done : b1.done;
  endfunction

  task automatic pulse_start(input int id);
    @(negedge clk);
    if (id == 0) b0.start = 1'b1;
    else         b1.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    b1.start = 1'b0;
  endtask

  task automatic start_run(input int id);
    wr_cnt[id] = 0;
    if (id == 1) have_prev1 = 1'b0;
    push_expected(id);
    pulse_start(id);
  endtask

  task automatic wait_done(input int id, input string name);
    int n;
    n = 0;
    while (done_of(id) !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, longint'(done_of(id)), 1);
    check({name, "_pending"}, longint'((id == 0) ? exp_q0.size() : exp_q1.size()), 0);
    check({name, "_writes"}, longint'(wr_cnt[id]), (id == 0) ? 16 : 32);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_wr_en"},   longint'(b0.mem_wr_en), 0);
    check({name, "_done"},    longint'(b0.done), 0);
    check({name, "_addr_rd"}, longint'(b0.addr_rd), 0);
    check({name, "_addr_wr"}, longint'(b0.addr_wr), 0);
    check({name, "_data_wr"}, longint'(b0.data_wr), 0);
    check({name, "_state"},   longint'(b0.state), longint'(ST_IDLE));
  endtask

  initial begin
    int n;
    int wc;
    b0.start = 1'b0;
    b1.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_k1_wr_en", longint'(b1.mem_wr_en), 0);
    check("reset_k1_addr_rd", longint'(b1.addr_rd), 0);
    check("reset_k1_state", longint'(b1.state), longint'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // all-ones: overlap counts per pixel
    fill(0, 0);
    start_run(0);
    wait_done(0, "ones");
    check("ones_corner", longint'(out_mem[0][0]), 4);
    check("ones_edge", longint'(out_mem[0][1]), 6);
    check("ones_interior", longint'(out_mem[0][5]), 9);
    check("ones_far_corner", longint'(out_mem[0][15]), 4);

    // K=1 identity with index data
    fill(1, 1);
    start_run(1);
    wait_done(1, "k1_index");
    check("k1_index_last", longint'(out_mem[1][31]), 31);
    check("k1_index_mid", longint'(out_mem[1][17]), 17);

    // saturation
    fill(0, 2);
    start_run(0);
    wait_done(0, "sat");
    check("sat_interior", longint'(out_mem[0][5]), 255);

    // randomized runs
    repeat (3) begin
      fill(0, 3);
      start_run(0);
      wait_done(0, "rand_k3");
      fill(1, 3);
      start_run(1);
      wait_done(1, "rand_k1");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    // reset while scanning pixel 5
    fill(0, 3);
    start_run(0);
    n = 0;
    while (!(wr_cnt[0] >= 5 && b0.state == ST_SCAN) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_pixel5", longint'(wr_cnt[0]), 5);
    rst = 1'b1;
    exp_q0.delete();
    wc = wr_cnt[0];
    #1;
    check_quiet("abort_async");
    @(posedge clk);
    #1;
    check_quiet("abort_edge");
    repeat (3) @(negedge clk);
    check("abort_no_writes", longint'(wr_cnt[0]), longint'(wc));
    rst = 1'b0;
    fill(0, 3);
    start_run(0);
    wait_done(0, "after_abort");

    // start during ACC is ignored
    fill(0, 3);
    start_run(0);
    n = 0;
    while (b0.state != ST_ACC && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("acc_reached", longint'(b0.state), longint'(ST_ACC));
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    wait_done(0, "start_in_acc");

    // start from DONE drops done and reruns
    fill(0, 3);
    start_run(0);
    check("restart_done_low", longint'(b0.done), 0);
    wait_done(0, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
